// File: rtl/fan_level_pwm_ctrl.sv
// rtl/fan_level_pwm_ctrl.sv - three-level fan controller with hysteresis, dwell and PWM drive
// Optional spin-up kick on OFF->LOW enabled by defining FAN_KICKSTART_EN.
module fan_level_pwm_ctrl #(
  parameter int TEMP_W     = 8,
  parameter int T_LOW_ON   = 20,
  parameter int T_LOW_OFF  = 15,
  parameter int T_HIGH_ON  = 28,
  parameter int T_HIGH_OFF = 24,
  parameter int DWELL_CYC  = 16,
  parameter int PWM_W      = 8,
  parameter int DUTY_LOW   = 128,
  parameter int DUTY_HIGH  = 255,
  parameter int KICK_CYC   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temperature,
  input  logic              temp_valid,
  output logic              fan_on,
  output logic [1:0]        fan_level,
  output logic              pwm_out,
  output logic              level_chg
);

  localparam int DW = $clog2(DWELL_CYC + 1);

  localparam logic [TEMP_W-1:0] LOW_ON_V   = TEMP_W'(T_LOW_ON);
  localparam logic [TEMP_W-1:0] LOW_OFF_V  = TEMP_W'(T_LOW_OFF);
  localparam logic [TEMP_W-1:0] HIGH_ON_V  = TEMP_W'(T_HIGH_ON);
  localparam logic [TEMP_W-1:0] HIGH_OFF_V = TEMP_W'(T_HIGH_OFF);
  localparam logic [DW-1:0]     DWELL_MAX  = DW'(DWELL_CYC);
  localparam logic [PWM_W-1:0]  DUTY_LOW_V  = PWM_W'(DUTY_LOW);
  localparam logic [PWM_W-1:0]  DUTY_HIGH_V = PWM_W'(DUTY_HIGH);

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_HIGH = 2'd2
  } level_e;

  level_e            level_q, level_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic              pwm_out_q, pwm_out_d;
  logic              fan_on_q, fan_on_d;
  logic              level_chg_q, level_chg_d;
  logic              eligible;
  logic              changed;
  logic [PWM_W-1:0]  duty;
  logic              cmp_hi;

`ifdef FAN_KICKSTART_EN
  localparam int KW = $clog2(KICK_CYC + 1);
  localparam logic [KW-1:0] KICK_LEN = KW'(KICK_CYC);
  logic [KW-1:0] kick_q, kick_d;
`endif

  always_comb begin
    eligible = temp_valid && (dwell_q == DWELL_MAX);
    level_d  = level_q;
    if (eligible) begin
      case (level_q)
        LVL_OFF:  if (temperature >= LOW_ON_V) level_d = LVL_LOW;
        LVL_LOW: begin
          if (temperature >= HIGH_ON_V)      level_d = LVL_HIGH;
          else if (temperature <= LOW_OFF_V) level_d = LVL_OFF;
        end
        LVL_HIGH: if (temperature <= HIGH_OFF_V) level_d = LVL_LOW;
        default:  level_d = LVL_OFF;
      endcase
    end
    changed     = (level_d != level_q);
    level_chg_d = changed;
    fan_on_d    = (level_d != LVL_OFF);

    if (changed)                 dwell_d = '0;
    else if (dwell_q == DWELL_MAX) dwell_d = dwell_q;
    else                         dwell_d = dwell_q + DW'(1);

    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    case (level_q)
      LVL_LOW:  duty = DUTY_LOW_V;
      LVL_HIGH: duty = DUTY_HIGH_V;
      default:  duty = '0;
    endcase
    // All-ones duty would otherwise drop for one count at the wrap point
    cmp_hi = (duty == '1) || (pwm_cnt_q < duty);

`ifdef FAN_KICKSTART_EN
    if (level_q == LVL_OFF && level_d == LVL_LOW) kick_d = KICK_LEN;
    else if (level_d == LVL_OFF)                  kick_d = '0;
    else if (kick_q != '0)                        kick_d = kick_q - KW'(1);
    else                                          kick_d = '0;
    pwm_out_d = cmp_hi || (kick_d != '0);
`else
    pwm_out_d = cmp_hi;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= LVL_OFF;
      dwell_q     <= DWELL_MAX;
      pwm_cnt_q   <= '0;
      pwm_out_q   <= 1'b0;
      fan_on_q    <= 1'b0;
      level_chg_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      dwell_q     <= dwell_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_out_q   <= pwm_out_d;
      fan_on_q    <= fan_on_d;
      level_chg_q <= level_chg_d;
    end
  end

`ifdef FAN_KICKSTART_EN
  always_ff @(posedge clk) begin
    if (rst) kick_q <= '0;
    else     kick_q <= kick_d;
  end
`endif

  assign fan_level = level_q;
  assign fan_on    = fan_on_q;
  assign pwm_out   = pwm_out_q;
  assign level_chg = level_chg_q;

endmodule

// File: tb/tb_fan_level_pwm_ctrl.sv
// tb/tb_fan_level_pwm_ctrl.sv - directed self-checking bench for fan_level_pwm_ctrl
module tb_fan_level_pwm_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] temperature;
  logic       temp_valid;
  logic       fan_on;
  logic [1:0] fan_level;
  logic       pwm_out;
  logic       level_chg;

  int pass_cnt;
  int total_cnt;

  fan_level_pwm_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .temperature(temperature),
    .temp_valid (temp_valid),
    .fan_on     (fan_on),
    .fan_level  (fan_level),
    .pwm_out    (pwm_out),
    .level_chg  (level_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    temp_valid = 1'b0;
    temperature = 8'd0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({fan_level, fan_on, pwm_out, level_chg} !== 5'b00000)
      $display("FAIL reset_outputs: got lvl=%0d on=%0b pwm=%0b chg=%0b, want all 0",
               fan_level, fan_on, pwm_out, level_chg);
    else pass_cnt++;
  endtask

  task automatic test_off_hold();
    int chg;
    int pw;
    chg = 0;
    pw = 0;
    temp_valid = 1'b1;
    temperature = 8'd10;
    for (int i = 0; i < 20; i++) begin tick(1); chg += level_chg; pw += pwm_out; end
    temperature = 8'd19;
    for (int i = 0; i < 20; i++) begin tick(1); chg += level_chg; pw += pwm_out; end
    total_cnt++;
    if (fan_level !== 2'd0) $display("FAIL off_hold_level: got %0d want 0", fan_level);
    else pass_cnt++;
    total_cnt++;
    if (chg != 0 || pw != 0) $display("FAIL off_hold_quiet: chg=%0d pwm=%0d want 0/0", chg, pw);
    else pass_cnt++;
  endtask

  task automatic test_low_entry();
    int chg;
    int pw;
    temperature = 8'd20;
    tick(1);
    total_cnt++;
    if ({fan_level, fan_on, level_chg} !== 4'b0111)
      $display("FAIL low_entry: got lvl=%0d on=%0b chg=%0b want 1/1/1", fan_level, fan_on, level_chg);
    else pass_cnt++;
    temperature = 8'd18;
    tick(1);
    total_cnt++;
    if (level_chg !== 1'b0) $display("FAIL low_chg_pulse: got %0b want 0", level_chg);
    else pass_cnt++;
    tick(40);
    chg = 0;
    pw = 0;
    for (int i = 0; i < 256; i++) begin tick(1); chg += level_chg; pw += pwm_out; end
    total_cnt++;
    if (pw != 128) $display("FAIL low_duty: got %0d high of 256 want 128", pw);
    else pass_cnt++;
    total_cnt++;
    if (chg != 0 || fan_level !== 2'd1)
      $display("FAIL low_hold_18: chg=%0d lvl=%0d want 0/1", chg, fan_level);
    else pass_cnt++;
  endtask

  task automatic test_low_to_off_dwell();
    do_reset();
    temp_valid = 1'b1;
    temperature = 8'd20;
    tick(1);
    temperature = 8'd15;
    tick(16);
    total_cnt++;
    if (fan_level !== 2'd1) $display("FAIL dwell_hold_low: got %0d want 1", fan_level);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({fan_level, fan_on, level_chg} !== 4'b0001)
      $display("FAIL low_to_off: got lvl=%0d on=%0b chg=%0b want 0/0/1", fan_level, fan_on, level_chg);
    else pass_cnt++;
    tick(2);
    total_cnt++;
    if (pwm_out !== 1'b0) $display("FAIL off_pwm: got %0b want 0", pwm_out);
    else pass_cnt++;
  endtask

  task automatic test_high_path();
    int pw;
    do_reset();
    temp_valid = 1'b1;
    temperature = 8'd30;
    tick(1);
    total_cnt++;
    if (fan_level !== 2'd1) $display("FAIL off_to_low_30: got %0d want 1", fan_level);
    else pass_cnt++;
    tick(16);
    total_cnt++;
    if (fan_level !== 2'd1) $display("FAIL low_dwell_30: got %0d want 1", fan_level);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (fan_level !== 2'd2 || level_chg !== 1'b1)
      $display("FAIL low_to_high: got lvl=%0d chg=%0b want 2/1", fan_level, level_chg);
    else pass_cnt++;
    tick(2);
    pw = 0;
    for (int i = 0; i < 256; i++) begin tick(1); pw += pwm_out; end
    total_cnt++;
    if (pw != 256) $display("FAIL high_duty: got %0d high of 256 want 256", pw);
    else pass_cnt++;
    temperature = 8'd25;
    tick(30);
    total_cnt++;
    if (fan_level !== 2'd2) $display("FAIL high_hold_25: got %0d want 2", fan_level);
    else pass_cnt++;
    temperature = 8'd24;
    tick(1);
    total_cnt++;
    if (fan_level !== 2'd1) $display("FAIL high_to_low_24: got %0d want 1", fan_level);
    else pass_cnt++;
    temperature = 8'd10;
    tick(16);
    total_cnt++;
    if (fan_level !== 2'd1) $display("FAIL low_hold_before_off: got %0d want 1", fan_level);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (fan_level !== 2'd0) $display("FAIL low_to_off_10: got %0d want 0", fan_level);
    else pass_cnt++;
  endtask

  task automatic test_valid_gate();
    int chg;
    do_reset();
    chg = 0;
    temp_valid = 1'b0;
    temperature = 8'd30;
    for (int i = 0; i < 20; i++) begin tick(1); chg += level_chg; end
    total_cnt++;
    if (fan_level !== 2'd0 || chg != 0)
      $display("FAIL valid_gate: got lvl=%0d chg=%0d want 0/0", fan_level, chg);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    temp_valid = 1'b1;
    temperature = 8'd30;
    tick(20);
    total_cnt++;
    if (fan_level !== 2'd2) $display("FAIL mid_reach_high: got %0d want 2", fan_level);
    else pass_cnt++;
    rst = 1'b1;
    tick(1);
    total_cnt++;
    if ({fan_level, fan_on, pwm_out, level_chg} !== 5'b00000)
      $display("FAIL mid_reset: got lvl=%0d on=%0b pwm=%0b chg=%0b want all 0",
               fan_level, fan_on, pwm_out, level_chg);
    else pass_cnt++;
    rst = 1'b0;
    temperature = 8'd20;
    tick(1);
    total_cnt++;
    if (fan_level !== 2'd1 || level_chg !== 1'b1)
      $display("FAIL post_reset_entry: got lvl=%0d chg=%0b want 1/1", fan_level, level_chg);
    else pass_cnt++;
  endtask

`ifdef FAN_KICKSTART_EN
  task automatic test_kick();
    int pw;
    do_reset();
    temp_valid = 1'b1;
    temperature = 8'd20;
    tick(1);
    pw = pwm_out;
    for (int i = 0; i < 63; i++) begin tick(1); pw += pwm_out; end
    total_cnt++;
    if (pw != 64) $display("FAIL kick_len: got %0d high of 64 want 64", pw);
    else pass_cnt++;
    tick(10);
    pw = 0;
    for (int i = 0; i < 256; i++) begin tick(1); pw += pwm_out; end
    total_cnt++;
    if (pw != 128) $display("FAIL kick_then_duty: got %0d want 128", pw);
    else pass_cnt++;
    do_reset();
    temp_valid = 1'b1;
    temperature = 8'd20;
    tick(1);
    temperature = 8'd15;
    tick(18);
    total_cnt++;
    if (fan_level !== 2'd0 || pwm_out !== 1'b0)
      $display("FAIL kick_abort: got lvl=%0d pwm=%0b want 0/0", fan_level, pwm_out);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    temp_valid = 1'b0;
    temperature = 8'd0;
    test_reset();
    test_off_hold();
    test_low_entry();
    test_low_to_off_dwell();
    test_high_path();
    test_valid_gate();
    test_reset_mid();
`ifdef FAN_KICKSTART_EN
    test_kick();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
